serial_add_sched: RTL and testbench

- Bit-serial adder scheduler that shares one gate-level 1-bit full-adder cell (XOR/NAND netlist, purely combinational, outside this block) among NREQ requesters.
- Grants one requester at a time using round-robin arbitration and captures its operands.
- Drives the shared cell LSB-first for WIDTH cycles and accumulates the sum and carry-out.
- Returns the result to the requester on a valid/ready response channel.
- Sits between the PPA-sim adder testbenches and the sized full-adder netlist. It lets one small cell stand in for a WIDTH-bit adder.

---
 rtl/serial_add_sched.sv | 151 +++++++++++++++
 tb/tb_serial_add_sched.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sched.sv
// Round-robin scheduler that time-shares one external 1-bit full-adder cell
// among NREQ requesters, adding WIDTH-bit operands LSB-first.
module serial_add_sched #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2,
    parameter int CW    = $clog2(WIDTH + 1),
    parameter int IW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NREQ-1:0]       req_valid_i,
    output logic [NREQ-1:0]       req_ready_o,
    input  logic [NREQ*WIDTH-1:0] req_a_i,
    input  logic [NREQ*WIDTH-1:0] req_b_i,
    output logic                  fa_a_o,
    output logic                  fa_b_o,
    output logic                  fa_cin_o,
    input  logic                  fa_sum_i,
    input  logic                  fa_cout_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [IW-1:0]         rsp_id_o,
    output logic [WIDTH-1:0]      rsp_sum_o,
    output logic                  rsp_cout_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_RESP
    } state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [IW-1:0]    rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic             rsp_cout_q, rsp_cout_d;

    logic             grant_vld;
    logic [IW-1:0]    grant_idx;
    logic [IW-1:0]    grant_nxt;
    logic [WIDTH-1:0] sum_shift;

    // Round-robin search starting at ptr, wrapping modulo NREQ.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!grant_vld && req_valid_i[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx[IW-1:0];
            end
        end
    end

    assign grant_nxt = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
    assign sum_shift = {fa_sum_i, sum_sh_q[WIDTH-1:1]};

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        sum_sh_d    = sum_sh_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        req_ready_o = '0;
        fa_a_o      = 1'b0;
        fa_b_o      = 1'b0;
        fa_cin_o    = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Reset wins: no accept is offered while rst is high.
                if (grant_vld && !rst_i) begin
                    req_ready_o[grant_idx] = 1'b1;
                    a_sh_d   = req_a_i[int'(grant_idx)*WIDTH +: WIDTH];
                    b_sh_d   = req_b_i[int'(grant_idx)*WIDTH +: WIDTH];
                    rsp_id_d = grant_idx;
                    ptr_d    = grant_nxt;
                    carry_d  = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                fa_a_o   = a_sh_q[0];
                fa_b_o   = b_sh_q[0];
                fa_cin_o = carry_q;
                sum_sh_d = sum_shift;
                carry_d  = fa_cout_i;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    rsp_sum_d  = sum_shift;
                    rsp_cout_d = fa_cout_i;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            sum_sh_q   <= '0;
            rsp_id_q   <= '0;
            rsp_sum_q  <= '0;
            rsp_cout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            carry_q    <= carry_d;
            cnt_q      <= cnt_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            sum_sh_q   <= sum_sh_d;
            rsp_id_q   <= rsp_id_d;
            rsp_sum_q  <= rsp_sum_d;
            rsp_cout_q <= rsp_cout_d;
        end
    end

    assign rsp_id_o   = rsp_id_q;
    assign rsp_sum_o  = rsp_sum_q;
    assign rsp_cout_o = rsp_cout_q;

endmodule

// File: tb/tb_serial_add_sched.sv
// Directed bench for serial_add_sched: arithmetic cell model, a transaction-level
// reference checked every cycle, and hand-computed literal expectations.
module tb_serial_add_sched;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        fa_a, fa_b, fa_cin, fa_sum, fa_cout;
    logic        rsp_valid, rsp_ready;
    logic [0:0]  rsp_id;
    logic [7:0]  rsp_sum;
    logic        rsp_cout;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    serial_add_sched #(.WIDTH(8), .NREQ(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b),
        .fa_a_o(fa_a), .fa_b_o(fa_b), .fa_cin_o(fa_cin),
        .fa_sum_i(fa_sum), .fa_cout_i(fa_cout),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_id_o(rsp_id), .rsp_sum_o(rsp_sum), .rsp_cout_o(rsp_cout)
    );

    // Shared full-adder cell
    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level reference: who should be granted, what the cell should
    // see on each bit slot, and what the response must carry.
    bit         busy = 1'b0;
    int         hs_cyc = 0;
    int         mptr = 0;
    int         mid = 0;
    int         ma = 0;
    int         mb = 0;

    always @(negedge clk) begin
        logic [1:0] exp_rdy;
        int k, m, tot;
        n_tests++;
        if ($countones(req_ready) > 1) begin
            n_fail++;
            $display("FAIL ready_onehot: got 0x%0h expected at most one bit", req_ready);
        end
        if (rst) begin
            busy = 1'b0;
            mptr = 0;
        end else if (!busy) begin
            exp_rdy = 2'b00;
            for (int j = 0; j < 2; j++) begin
                int idx;
                idx = (mptr + j) % 2;
                if (exp_rdy == 2'b00 && req_valid[idx]) exp_rdy[idx] = 1'b1;
            end
            chk("m_idle_ready", req_ready, exp_rdy);
            chk("m_idle_rsp_valid", rsp_valid, 0);
            chk("m_idle_fa", {fa_a, fa_b, fa_cin}, 0);
            if (|(req_ready & req_valid)) begin
                busy   = 1'b1;
                hs_cyc = cyc;
                mid    = exp_rdy[1] ? 1 : 0;
                ma     = int'(req_a[mid*8 +: 8]);
                mb     = int'(req_b[mid*8 +: 8]);
                mptr   = (mid + 1) % 2;
            end
        end else begin
            k = cyc - hs_cyc;
            chk("m_busy_ready", req_ready, 0);
            if (k <= 8) begin
                m = (1 << (k - 1)) - 1;
                chk("m_run_rsp_valid", rsp_valid, 0);
                chk("m_run_fa_a", fa_a, (ma >> (k - 1)) & 1);
                chk("m_run_fa_b", fa_b, (mb >> (k - 1)) & 1);
                chk("m_run_fa_cin", fa_cin, (((ma & m) + (mb & m)) >> (k - 1)) & 1);
            end else begin
                tot = ma + mb;
                chk("m_rsp_valid", rsp_valid, 1);
                chk("m_rsp_id", rsp_id, mid);
                chk("m_rsp_sum", rsp_sum, tot & 255);
                chk("m_rsp_cout", rsp_cout, (tot >> 8) & 1);
                chk("m_rsp_fa", {fa_a, fa_b, fa_cin}, 0);
                if (rsp_ready) busy = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(output int c);
        bit got = 1'b0;
        c = -1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (|(req_ready & req_valid)) begin
                got = 1'b1;
                c   = cyc;
            end
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL hs_timeout: got no req handshake expected one within 100 cycles");
        end
    endtask

    task automatic wait_rsp(output int c);
        bit got = 1'b0;
        c = -1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                c   = cyc;
            end
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL rsp_timeout: got no rsp_valid expected one within 100 cycles");
        end
    endtask

    initial begin
        int t, r, nhs, nrsp;
        int ids[3];
        rst = 1'b1; req_valid = 2'b00; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_sum", rsp_sum, 0);
        chk("rst_rsp_cout", rsp_cout, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_fa", {fa_a, fa_b, fa_cin}, 0);

        // req0: 0x5A + 0x3C
        tick();
        req_a[7:0] = 8'h5A; req_b[7:0] = 8'h3C; req_valid = 2'b01; rsp_ready = 1'b1;
        wait_hs(t);
        chk("t1_ready", req_ready, 2'b01);
        tick(); req_valid = 2'b00;
        wait_rsp(r);
        chk("t1_latency", r - t, 9);
        chk("t1_sum", rsp_sum, 8'h96);
        chk("t1_cout", rsp_cout, 0);
        chk("t1_id", rsp_id, 0);

        // req1: 0xFF + 0x01, carry ripples through every slot
        tick();
        req_a[15:8] = 8'hFF; req_b[15:8] = 8'h01; req_valid = 2'b10;
        wait_hs(t);
        tick(); req_valid = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("t2_fa_cin", fa_cin, (k == 1) ? 0 : 1);
        end
        wait_rsp(r);
        chk("t2_sum", rsp_sum, 8'h00);
        chk("t2_cout", rsp_cout, 1);
        chk("t2_id", rsp_id, 1);

        // Both requesters held valid from reset: grant order 0,1,0
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        req_a = {8'h40, 8'h11}; req_b = {8'h80, 8'h22}; req_valid = 2'b11;
        nhs = 0; nrsp = 0;
        for (int i = 0; i < 200 && nrsp < 3; i++) begin
            @(negedge clk);
            if (|(req_ready & req_valid)) nhs++;
            if (rsp_valid && rsp_ready) begin
                ids[nrsp] = int'(rsp_id);
                nrsp++;
            end
            if (nhs == 3 && req_valid != 2'b00) begin
                @(posedge clk); #1;
                req_valid = 2'b00;
            end
        end
        chk("t3_nrsp", nrsp, 3);
        chk("t3_id0", ids[0], 0);
        chk("t3_id1", ids[1], 1);
        chk("t3_id2", ids[2], 0);

        // Back-pressure: rsp_ready low for 5 cycles, req1 waiting meanwhile
        tick();
        req_a[7:0] = 8'h81; req_b[7:0] = 8'h7F; req_valid = 2'b01; rsp_ready = 1'b0;
        wait_hs(t);
        tick();
        req_valid = 2'b10; req_a[15:8] = 8'h33; req_b[15:8] = 8'h44;
        wait_rsp(r);
        chk("t4_sum", rsp_sum, 8'h00);
        chk("t4_cout", rsp_cout, 1);
        repeat (5) tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t4_held_valid", rsp_valid, 1);
        chk("t4_held_sum", rsp_sum, 8'h00);
        tick();
        @(negedge clk);
        chk("t4_idle_grant", req_ready, 2'b10);
        tick(); req_valid = 2'b00;
        wait_rsp(r);
        chk("t4_sum2", rsp_sum, 8'h77);
        chk("t4_id2", rsp_id, 1);

        // Reset on the 3rd RUN cycle of req0 (0x10+0x20)
        tick();
        req_a[7:0] = 8'h10; req_b[7:0] = 8'h20; req_valid = 2'b01;
        wait_hs(t);
        tick(); req_valid = 2'b00;
        tick();
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("t5_rsp_valid", rsp_valid, 0);
        chk("t5_fa", {fa_a, fa_b, fa_cin}, 0);
        chk("t5_ready", req_ready, 0);
        tick();
        req_a[15:8] = 8'h01; req_b[15:8] = 8'h02; req_valid = 2'b10;
        wait_hs(t);
        chk("t5_grant", req_ready, 2'b10);
        tick(); req_valid = 2'b00;
        wait_rsp(r);
        chk("t5_sum", rsp_sum, 8'h03);
        chk("t5_cout", rsp_cout, 0);
        chk("t5_id", rsp_id, 1);

        // 0x00 + 0x00, then a quiet idle stretch
        tick();
        req_a[7:0] = 8'h00; req_b[7:0] = 8'h00; req_valid = 2'b01;
        wait_hs(t);
        tick(); req_valid = 2'b00;
        wait_rsp(r);
        chk("t6_sum", rsp_sum, 8'h00);
        chk("t6_cout", rsp_cout, 0);
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t6_idle_fa", {fa_a, fa_b, fa_cin}, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
